alu_result_fifo: RTL
====================

# alu_result_fifo

Downstream result stage for the 4-bit combinational ALU. It captures each ALU result, carry-out and opcode under a valid/ready handshake, and tags each entry with a zero flag computed at capture. Entries are buffered in a small first-word-fall-through FIFO. The consumer (register writeback or test monitor) drains them in order at its own pace.

## Interface
- BW_DATA, 4, width of ALU result; must match the ALU's BW_DATA
- DEPTH, 4, number of entries; power of two, ≥ 2
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  upstream has a result to push
- o_ready  output  1  FIFO can accept a push this cycle
- i_Y  input  BW_DATA  ALU result
- i_Cout  input  1  ALU carry-out
- i_F  input  3  ALU opcode that produced i_Y
- o_valid  output  1  head entry available
- i_ready  input  1  downstream accepts head this cycle
- o_Y  output  BW_DATA  head result
- o_Cout  output  1  head carry
- o_F  output  3  head opcode
- o_Z  output  1  head zero flag (stored result == 0)
- o_count  output  $clog2(DEPTH)+1  current occupancy
- o_full  output  1  o_count == DEPTH
- o_empty  output  1  o_count == 0

## Operation
- Entry = {F[2:0], Z, Cout, Y[BW_DATA-1:0]}, width BW_DATA+5.
- Z is computed at push time as (i_Y == 0). Z is independent of Cout.
- Push = i_valid & o_ready. Pop = o_valid & i_ready.
- o_ready = ~o_full. The ready signal depends only on occupancy, so a pop in the same cycle does not enable a push when the FIFO is full.
- o_valid = ~o_empty.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Count is a separate counter.
  - Push only: count+1. Pop only: count−1. Both: count unchanged, both pointers advance.
- First-word-fall-through: o_Y/o_Cout/o_F/o_Z show mem[rd_ptr] combinationally whenever o_valid=1.
- When o_empty=1, data outputs are forced to 0.
- i_valid while o_full: no write and no state change. Upstream must hold its data; the block never drops or overwrites an entry.
- i_ready while o_empty: ignored, and count never underflows.
- Storage is not reset. Only the pointers and count are reset.
- Reset mid-operation discards all entries.

## Timing
- Reset (i_rst=1 at an edge) sets wr_ptr=0, rd_ptr=0, count=0.
- After reset: o_valid=0, o_empty=1, o_full=0, o_ready=1, o_count=0, o_Y=0, o_Cout=0, o_F=0, o_Z=0.
- i_rst has priority over a push or pop in the same cycle.
- Latency: an entry pushed at edge N appears on the outputs with o_valid=1 in the cycle after edge N.
- There is no combinational path from i_valid to o_valid.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- All outputs except the head data depend only on registered state. There are no combinational paths from i_valid or i_ready to any output.

## Test plan
- Reset/idle:
  - Stimulus: assert i_rst for 2 cycles with i_valid=1, i_Y=4'hF.
  - Response: after release, o_count=0, o_valid=0, o_ready=1, all data outputs 0, and no entry was written during reset.
- Single entry and flags:
  - Stimulus: push Y=4'h0, Cout=1, F=3'b010.
  - Response: next cycle o_valid=1, o_Y=0, o_Cout=1, o_F=2, o_Z=1.
  - Then pop with i_ready=1. Response: o_empty=1.
- Fill to full:
  - Stimulus: push 1,2,3,4 with F=0..3 while i_ready=0.
  - Response: o_count=4, o_full=1, o_ready=0.
  - Stimulus: present a 5th value 9 with i_valid=1. Response: ignored, count stays 4, head stays 1.
- Drain and wrap:
  - Stimulus: from full, pop 2 entries, push 5 and 6, then pop all.
  - Response: output order 1,2,3,4,5,6, with the pointers wrapping past DEPTH−1.
  - Z=0 for every entry.
- Simultaneous push/pop:
  - Stimulus: at count=2, hold i_valid=1 and i_ready=1 for 6 cycles with an incrementing Y.
  - Response: o_count stays 2 and outputs appear in push order.
  - Stimulus: at count=4 with both valid and ready asserted. Response: pop only, count drops to 3.
- Reset mid-stream:
  - Stimulus: at count=3, assert i_rst for 1 cycle while i_valid=1 and i_ready=1.
  - Response: count=0 and o_valid=0 the next cycle.
  - A subsequent push of 4'hA is read back first.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Result stage for the 4-bit ALU: captures {F, Z, Cout, Y} under valid/ready
// into a small first-word-fall-through FIFO drained in order by the consumer.
module alu_result_fifo #(
    parameter int BW_DATA = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [BW_DATA-1:0]         i_Y,
    input  logic                       i_Cout,
    input  logic [2:0]                 i_F,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [BW_DATA-1:0]         o_Y,
    output logic                       o_Cout,
    output logic [2:0]                 o_F,
    output logic                       o_Z,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = BW_DATA + 5;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_zero;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready is derived from occupancy alone, so a simultaneous pop never opens
    // a slot for a push when full; this keeps i_ready off the o_ready path.
    assign w_push  = i_valid & ~w_full;
    assign w_pop   = i_ready & ~w_empty;

    assign w_zero  = (i_Y == '0);
    assign w_entry = {i_F, w_zero, i_Cout, i_Y};

    // Storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign w_head  = r_mem[r_rd_ptr];

    assign o_ready = ~w_full;
    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

    // Head data is masked to zero while empty so stale storage never leaks out.
    assign o_Y    = w_empty ? '0   : w_head[BW_DATA-1:0];
    assign o_Cout = w_empty ? 1'b0 : w_head[BW_DATA];
    assign o_Z    = w_empty ? 1'b0 : w_head[BW_DATA+1];
    assign o_F    = w_empty ? 3'b0 : w_head[BW_DATA+4:BW_DATA+2];

endmodule
